// File: rtl/cpu_trace_dump.sv
// Debug snapshot streamer: free-running cycle/stall/flush counters plus an on-demand dump
// of a header (counters, PC), the register file and the low data-memory words over a valid/ready stream.
module cpu_trace_dump #(
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        cnt_clr_i,
  input  logic        dump_req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int TOTAL = 4 + NUM_REGS + MEM_WORDS;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(32'd0);
  localparam logic [IDX_W-1:0] FIRST_REG = IDX_W'(32'd4);
  localparam logic [IDX_W-1:0] FIRST_MEM = IDX_W'(32'(4 + NUM_REGS));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(32'(TOTAL - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_REG  = 2'd2,
    S_MEM  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        data_q, data_d;
  logic               last_q, last_d;
  logic [4:0]         rptr_q, rptr_d;
  logic [31:0]        mptr_q, mptr_d;
  logic [31:0]        hdr_cyc_q, hdr_cyc_d, hdr_stl_q, hdr_stl_d;
  logic [31:0]        hdr_fls_q, hdr_fls_d, hdr_pc_q, hdr_pc_d;
  logic [31:0]        cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d;
  logic [IDX_W-1:0]   nidx_s, nnidx_s;
  logic [31:0]        word_s;

  function automatic logic is_reg(input logic [IDX_W-1:0] n);
    return (n >= FIRST_REG) && (n < FIRST_MEM);
  endfunction

  function automatic logic is_mem(input logic [IDX_W-1:0] n);
    return (n >= FIRST_MEM);
  endfunction

  always_comb begin
    if (cnt_clr_i) begin
      cyc_d = 32'd0;
      stl_d = 32'd0;
      fls_d = 32'd0;
    end else begin
      cyc_d = cyc_q + 32'd1;
      stl_d = stl_q + {31'd0, stall_i & ~flush_i};
      fls_d = fls_q + {31'd0, flush_i};
    end
  end

  // Value of the word that a transfer this cycle would load next; register and
  // memory contents are taken live from the read ports at that edge.
  always_comb begin
    nidx_s  = idx_q + IDX_ONE;
    nnidx_s = nidx_s + IDX_ONE;
    word_s  = 32'd0;
    if (nidx_s < FIRST_REG) begin
      case (nidx_s[1:0])
        2'd0:    word_s = hdr_cyc_q;
        2'd1:    word_s = hdr_stl_q;
        2'd2:    word_s = hdr_fls_q;
        default: word_s = hdr_pc_q;
      endcase
    end else if (nidx_s < FIRST_MEM) begin
      word_s = reg_data_i;
    end else begin
      word_s = mem_data_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    rptr_d    = rptr_q;
    mptr_d    = mptr_q;
    hdr_cyc_d = hdr_cyc_q;
    hdr_stl_d = hdr_stl_q;
    hdr_fls_d = hdr_fls_q;
    hdr_pc_d  = hdr_pc_q;
    case (state_q)
      S_IDLE: begin
        if (dump_req_i) begin
          hdr_cyc_d = cyc_q;
          hdr_stl_d = stl_q;
          hdr_fls_d = fls_q;
          hdr_pc_d  = pc_i;
          data_d    = cyc_q;
          last_d    = 1'b0;
          idx_d     = IDX_ZERO;
          rptr_d    = 5'd0;
          mptr_d    = 32'd0;
          state_d   = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR, S_REG, S_MEM: begin
        if (!out_ready_i) begin
          state_d = state_q;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = IDX_ZERO;
          last_d  = 1'b0;
          rptr_d  = 5'd0;
          mptr_d  = 32'd0;
        end else begin
          idx_d  = nidx_s;
          data_d = word_s;
          last_d = (nidx_s == LAST_IDX);
          // Read pointers always address the word after the one now being loaded.
          rptr_d = is_reg(nnidx_s) ? (is_reg(nidx_s) ? rptr_q + 5'd1 : 5'd0) : 5'd0;
          mptr_d = is_mem(nnidx_s) ? (is_mem(nidx_s) ? mptr_q + 32'd4 : 32'd0) : 32'd0;
          if (nidx_s < FIRST_REG) begin
            state_d = S_HDR;
          end else if (nidx_s < FIRST_MEM) begin
            state_d = S_REG;
          end else begin
            state_d = S_MEM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      idx_q     <= IDX_ZERO;
      data_q    <= 32'd0;
      last_q    <= 1'b0;
      rptr_q    <= 5'd0;
      mptr_q    <= 32'd0;
      hdr_cyc_q <= 32'd0;
      hdr_stl_q <= 32'd0;
      hdr_fls_q <= 32'd0;
      hdr_pc_q  <= 32'd0;
      cyc_q     <= 32'd0;
      stl_q     <= 32'd0;
      fls_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      rptr_q    <= rptr_d;
      mptr_q    <= mptr_d;
      hdr_cyc_q <= hdr_cyc_d;
      hdr_stl_q <= hdr_stl_d;
      hdr_fls_q <= hdr_fls_d;
      hdr_pc_q  <= hdr_pc_d;
      cyc_q     <= cyc_d;
      stl_q     <= stl_d;
      fls_q     <= fls_d;
    end
  end

  assign reg_addr_o  = rptr_q;
  assign mem_addr_o  = mptr_q;
  assign out_valid_o = (state_q != S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign cycle_cnt_o = cyc_q;
  assign stall_cnt_o = stl_q;
  assign flush_cnt_o = fls_q;

endmodule

// File: tb/tb_cpu_trace_dump.sv
// Bench for cpu_trace_dump: counter vector table, directed dump sequences and a
// randomized run, all checked against a word-list reference model of the dump.
module tb_cpu_trace_dump;
  localparam int NR  = 32;
  localparam int MW  = 8;
  localparam int TOT = 4 + NR + MW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush, cnt_clr, dump_req, out_ready;
  logic [31:0] pc;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, mem_addr, mem_data, out_data, cyc_o, stl_o, fls_o;
  logic        out_valid, out_last, busy;
  logic [31:0] regs [NR];
  logic [31:0] mem  [MW];

  assign reg_data = regs[reg_addr];
  assign mem_data = (mem_addr < 32'(4 * MW)) ? mem[mem_addr[4:2]] : 32'hDEAD_BEEF;

  cpu_trace_dump #(.NUM_REGS(NR), .MEM_WORDS(MW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .pc_i(pc),
    .cnt_clr_i(cnt_clr), .dump_req_i(dump_req), .reg_addr_o(reg_addr),
    .reg_data_i(reg_data), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .busy_o(busy), .cycle_cnt_o(cyc_o),
    .stall_cnt_o(stl_o), .flush_cnt_o(fls_o)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_cyc, m_stl, m_fls, l_cyc, l_stl, l_fls, l_pc, m_exp;
  bit          m_busy;
  int          m_k;
  logic [31:0] words[$];
  logic [31:0] ref_words[$];
  bit          lasts[$];

  typedef struct {
    bit          s, f, c;
    logic [31:0] e_cyc, e_stl, e_fls;
  } cnt_vec_t;
  cnt_vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_val(input int k);
    if (k == 0)           return l_cyc;
    else if (k == 1)      return l_stl;
    else if (k == 2)      return l_fls;
    else if (k == 3)      return l_pc;
    else if (k < 4 + NR)  return regs[k - 4];
    else                  return mem[k - 4 - NR];
  endfunction

  task automatic model_reset();
    m_cyc = 32'd0; m_stl = 32'd0; m_fls = 32'd0;
    l_cyc = 32'd0; l_stl = 32'd0; l_fls = 32'd0; l_pc = 32'd0;
    m_exp = 32'd0; m_busy = 1'b0; m_k = 0;
  endtask

  task automatic check_outputs();
    chk("valid", 32'(out_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cycle_cnt", cyc_o, m_cyc);
    chk("stall_cnt", stl_o, m_stl);
    chk("flush_cnt", fls_o, m_fls);
    if (m_busy) begin
      chk($sformatf("data_w%0d", m_k), out_data, m_exp);
      chk($sformatf("last_w%0d", m_k), 32'(out_last), 32'(m_k == TOT - 1));
    end else begin
      chk("idle_reg_addr", 32'(reg_addr), 32'd0);
      chk("idle_mem_addr", mem_addr, 32'd0);
    end
  endtask

  // One clock: advance the model with the inputs currently applied, clock, then compare.
  task automatic tick();
    logic [31:0] pre_data;
    logic        pre_last;
    bit          pre_hold;
    pre_hold = out_valid && !out_ready;
    pre_data = out_data;
    pre_last = out_last;
    if (out_valid && out_ready) begin
      words.push_back(out_data);
      lasts.push_back(out_last);
    end
    if (m_busy && out_ready) begin
      if (m_k == TOT - 1) m_busy = 1'b0;
      else begin
        m_k   = m_k + 1;
        m_exp = word_val(m_k);
      end
    end else if (!m_busy && dump_req) begin
      l_cyc = m_cyc; l_stl = m_stl; l_fls = m_fls; l_pc = pc;
      m_busy = 1'b1; m_k = 0; m_exp = m_cyc;
    end
    if (cnt_clr) begin
      m_cyc = 32'd0; m_stl = 32'd0; m_fls = 32'd0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (stall && !flush) m_stl = m_stl + 32'd1;
      if (flush) m_fls = m_fls + 32'd1;
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (pre_hold) begin
      chk("hold_data", out_data, pre_data);
      chk("hold_last", 32'(out_last), 32'(pre_last));
    end
  endtask

  initial begin
    int nlast;
    int diffs;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; dump_req = 1'b0;
    out_ready = 1'b0; pc = 32'd0;
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < MW; i++) mem[i] = 32'hA000_0000 + 32'(i);
    regs[8] = 32'd5;
    mem[0]  = 32'd5;
    model_reset();

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd1,  32'd1, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'd2,  32'd1, 32'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'd3,  32'd1, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'd4,  32'd1, 32'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'd5,  32'd2, 32'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'd6,  32'd2, 32'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd7,  32'd2, 32'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'd8,  32'd2, 32'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'd9,  32'd2, 32'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'd10, 32'd2, 32'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'd0,  32'd0, 32'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'd1,  32'd1, 32'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_cycle", cyc_o, 32'd0);
    rst_n = 1'b1;

    // counter vector table
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].s; flush = vecs[i].f; cnt_clr = vecs[i].c;
      tick();
      chk($sformatf("vec%0d_cycle", i), cyc_o, vecs[i].e_cyc);
      chk($sformatf("vec%0d_stall", i), stl_o, vecs[i].e_stl);
      chk($sformatf("vec%0d_flush", i), fls_o, vecs[i].e_fls);
    end
    stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;

    // full-throughput dump
    words.delete(); lasts.delete();
    pc = 32'h40; out_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (TOT + 1) tick();
    chk("d1_count", 32'(words.size()), 32'(TOT));
    if (words.size() == TOT) begin
      chk("d1_word3", words[3], 32'h40);
      chk("d1_word12", words[12], 32'd5);
      chk("d1_word36", words[36], 32'd5);
      nlast = 0;
      foreach (lasts[i]) if (lasts[i]) nlast++;
      chk("d1_last_count", 32'(nlast), 32'd1);
      chk("d1_last_pos", 32'(lasts[TOT - 1]), 32'd1);
    end
    ref_words = words;

    // dump with ready toggling every cycle; PC changes after the request
    words.delete(); lasts.delete();
    out_ready = 1'b0; dump_req = 1'b1;
    tick();
    dump_req = 1'b0; pc = 32'h1234;
    for (int i = 0; i < 200 && m_busy; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    chk("d2_done", 32'(busy), 32'd0);
    chk("d2_count", 32'(words.size()), 32'(TOT));
    if (words.size() == TOT && ref_words.size() == TOT) begin
      diffs = 0;
      for (int i = 3; i < TOT; i++) if (words[i] !== ref_words[i]) diffs++;
      chk("d2_seq_match", 32'(diffs), 32'd0);
    end

    // requests during the dump, including on the final transfer edge, are ignored
    out_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 60 && m_busy; i++) begin
      dump_req = (m_k == 10 || m_k == TOT - 1);
      tick();
    end
    dump_req = 1'b0;
    repeat (3) tick();
    chk("d3_busy_after", 32'(busy), 32'd0);

    // reset in the middle of a dump
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 60 && m_k < 20; i++) tick();
    chk("d4_at_word20", 32'(m_k), 32'd20);
    rst_n = 1'b0;
    #2;
    chk("d4_rst_valid", 32'(out_valid), 32'd0);
    chk("d4_rst_busy", 32'(busy), 32'd0);
    chk("d4_rst_cycle", cyc_o, 32'd0);
    chk("d4_rst_stall", stl_o, 32'd0);
    chk("d4_rst_flush", fls_o, 32'd0);
    chk("d4_rst_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (6) tick();

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      stall     = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 3) == 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      dump_req  = ($urandom_range(0, 9) == 0);
      pc        = $urandom;
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NR - 1)] = $urandom;
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, MW - 1)] = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_trace_dump.md
CPU_TRACE_DUMP -- requirements
Module: cpu_trace_dump

Interface
REQ-001 Parameter NUM_REGS, default 32, number of register-file words dumped (R0 upward).
REQ-002 Parameter MEM_WORDS, default 8, number of 32-bit data-memory words dumped from byte address 0x00 upward.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 stall_i  input  1  pipeline load-use stall this cycle.
REQ-006 flush_i  input  1  branch flush this cycle.
REQ-007 pc_i  input  32  current PC register value.
REQ-008 cnt_clr_i  input  1  synchronous clear of all three counters.
REQ-009 dump_req_i  input  1  request a snapshot dump.
REQ-010 reg_addr_o  output  5  register-file read address (combinational read port).
REQ-011 reg_data_i  input  32  register-file read data for reg_addr_o, same cycle.
REQ-012 mem_addr_o  output  32  data-memory byte address, word aligned (combinational read port).
REQ-013 mem_data_i  input  32  little-endian word at mem_addr_o, same cycle.
REQ-014 out_valid_o / out_ready_i / out_data_o (32) / out_last_o  output/input/output/output  dump word stream.
REQ-015 busy_o  output  1  dump in progress.
REQ-016 cycle_cnt_o, stall_cnt_o, flush_cnt_o  output  32 each  live event counters.

Function
REQ-017 cycle_cnt_o SHALL increment by 1 every clock edge out of reset, wrapping modulo 2^32.
REQ-018 stall_cnt_o SHALL increment when stall_i=1 and flush_i=0; flush_cnt_o SHALL increment when flush_i=1; both wrap modulo 2^32.
REQ-019 cnt_clr_i=1 SHALL load all three counters with 0 on that edge, overriding any same-cycle increment.
REQ-020 Counters SHALL keep counting during a dump.
REQ-021 FSM states: IDLE, HDR, REG, MEM; word index 0..(3+NUM_REGS+MEM_WORDS).
REQ-022 In IDLE with dump_req_i=1, on the edge: latch cycle, stall, flush counters and pc_i into header holding registers, load out_data_o with latched cycle count, assert out_valid_o, enter HDR; busy_o=1 from that edge.
REQ-023 Word order: 0 cycle, 1 stall, 2 flush, 3 PC (all from the latch), then R0..R(NUM_REGS-1), then memory words at 0x00, 0x04, ... 4*(MEM_WORDS-1).
REQ-024 A word SHALL transfer on an edge with out_valid_o=1 and out_ready_i=1; the next word SHALL be loaded on that same edge (one word per cycle at full throughput).
REQ-025 While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o SHALL hold stable.
REQ-026 reg_addr_o/mem_addr_o SHALL be driven from the index of the next word to load; the register/memory value SHALL be sampled at the load edge (live value, not frozen at request).
REQ-027 HDR->REG after word 3 transfers; REG->MEM after R(NUM_REGS-1) transfers; MEM->IDLE after the last word transfers.
REQ-028 out_last_o=1 only with the final memory word; on its transfer out_valid_o and busy_o SHALL drop next cycle.
REQ-029 dump_req_i while busy_o=1, including on the final transfer edge, SHALL be ignored.
REQ-030 In IDLE, reg_addr_o=0 and mem_addr_o=0.

Reset
REQ-031 rst_n_i=0 SHALL immediately force IDLE, index 0, all counters 0, header latches 0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0.
REQ-032 Reset mid-dump SHALL abort the dump; no further words after release until a new dump_req_i.

Verification
REQ-033 Release reset, 10 edges, stall_i=1 on 3 of them (one with flush_i=1), flush_i=1 on 2 -> cycle_cnt_o=10, stall_cnt_o=2, flush_cnt_o=2.
REQ-034 cnt_clr_i=1 with stall_i=1 same edge -> all counters 0 next cycle.
REQ-035 Preload R8=5, mem 0x00=5, pc_i=0x40, out_ready_i=1, pulse dump_req_i -> 44 consecutive words, word 3=0x40, word 12=5, word 36=5, out_last_o only on word 43.
REQ-036 Same dump, out_ready_i toggled 0/1 every cycle -> identical 44-word sequence, out_data_o stable during every ready=0 cycle.
REQ-037 dump_req_i pulsed at word 10 and on the final-transfer edge -> ignored; busy_o low after word 43.
REQ-038 rst_n_i low at word 20 -> out_valid_o, busy_o, counters 0 without a clock edge; no output until next dump_req_i.
